// File: rtl/rf_write_arbiter_if.sv
// Bundle of the WB, MDU and register-file write-port signals seen by rf_write_arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/bench view.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_waddr;
  logic [DATA_W-1:0] mdu_wdata;
  logic              mdu_ready;
  logic              stall_req;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, mdu_valid, mdu_waddr, mdu_wdata,
    output mdu_ready, stall_req, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output wb_we, wb_waddr, wb_wdata, mdu_valid, mdu_waddr, mdu_wdata,
    input  mdu_ready, stall_req, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB (fixed priority) and the MDU, with a
// starvation bound that stalls the pipeline and forces an MDU grant.
module rf_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rf_write_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             stall_q;
  logic             wb_act;
  logic             grant_wb, grant_mdu;
  logic             sel_wb, sel_mdu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign wb_act = bus.wb_we && (bus.wb_waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      stall_q  <= (state_nxt == FORCE);
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    grant_wb     = 1'b0;
    grant_mdu    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.mdu_valid && !wb_act) begin
          grant_mdu = 1'b1;
        end else if (bus.mdu_valid) begin
          grant_wb     = 1'b1;
          wait_cnt_nxt = CNT_W'(1);
          state_nxt    = (MAX_WAIT == 1) ? FORCE : WAIT;
        end else begin
          grant_wb = wb_act;
        end
      end
      WAIT: begin
        // An MDU that drops its request here has broken the protocol; just fall back.
        if (!bus.mdu_valid) begin
          grant_wb     = wb_act;
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else if (!wb_act) begin
          grant_mdu    = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          grant_wb     = 1'b1;
          wait_cnt_nxt = sat_inc(wait_cnt);
          if (wait_cnt == CNT_LAST) state_nxt = FORCE;
        end
      end
      FORCE: begin
        // WB is frozen by stall_req, so the MDU owns the port this cycle.
        grant_mdu    = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = IDLE;
      end
      default: begin
        wait_cnt_nxt = '0;
        state_nxt    = IDLE;
      end
    endcase
  end

  assign sel_wb  = rst_n && grant_wb;
  assign sel_mdu = rst_n && grant_mdu;

  assign bus.mdu_ready = sel_mdu;
  assign bus.stall_req = stall_q;
  assign bus.rf_we     = (sel_wb && wb_act) ||
                         (sel_mdu && bus.mdu_valid && (bus.mdu_waddr != '0));
  assign bus.rf_waddr  = sel_mdu ? bus.mdu_waddr : (sel_wb ? bus.wb_waddr : '0);
  assign bus.rf_wdata  = sel_mdu ? bus.mdu_wdata : (sel_wb ? bus.wb_wdata : '0);
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed-vector bench for rf_write_arbiter with hand-computed expectations and a
// register-file model fed from the write port.
module tb_rf_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [DATA_W-1:0] mem [32];

  rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs in the low phase, then settle before checks.
  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    @(negedge clk);
    bus.wb_we     = wv;
    bus.wb_waddr  = wa;
    bus.wb_wdata  = wd;
    bus.mdu_valid = mv;
    bus.mdu_waddr = ma;
    bus.mdu_wdata = md;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rst_n = 1'b0;

    // Reset holds outputs quiet even with both requesters active
    drive(1'b1, 5'd3, 32'h1111_1111, 1'b1, 5'd4, 32'h2222_2222);
    check("rst_rf_we",     32'(bus.rf_we),     32'd0);
    check("rst_mdu_ready", 32'(bus.mdu_ready), 32'd0);
    check("rst_stall",     32'(bus.stall_req), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    #1;
    check("idle_rf_we",    32'(bus.rf_we),    32'd0);
    check("idle_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("idle_rf_wdata", bus.rf_wdata,      32'd0);

    // WB only
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    check("wb_rf_we",      32'(bus.rf_we),     32'd1);
    check("wb_rf_waddr",   32'(bus.rf_waddr),  32'd5);
    check("wb_rf_wdata",   bus.rf_wdata,       32'hDEAD_BEEF);
    check("wb_mdu_ready",  32'(bus.mdu_ready), 32'd0);

    // MDU alone
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234_5678);
    check("wb_reg5",       mem[5],             32'hDEAD_BEEF);
    check("mdu_ready",     32'(bus.mdu_ready), 32'd1);
    check("mdu_rf_we",     32'(bus.rf_we),     32'd1);
    check("mdu_rf_waddr",  32'(bus.rf_waddr),  32'd9);
    check("mdu_rf_wdata",  bus.rf_wdata,       32'h1234_5678);

    // Contention: two WB cycles, then MDU gets the port
    drive(1'b1, 5'd7, 32'hA1, 1'b1, 5'd10, 32'hCAFE_0010);
    check("mdu_reg9",      mem[9],             32'h1234_5678);
    check("ct1_ready",     32'(bus.mdu_ready), 32'd0);
    check("ct1_waddr",     32'(bus.rf_waddr),  32'd7);
    drive(1'b1, 5'd8, 32'hA2, 1'b1, 5'd10, 32'hCAFE_0010);
    check("ct2_ready",     32'(bus.mdu_ready), 32'd0);
    check("ct2_waddr",     32'(bus.rf_waddr),  32'd8);
    check("ct2_stall",     32'(bus.stall_req), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hCAFE_0010);
    check("ct3_ready",     32'(bus.mdu_ready), 32'd1);
    check("ct3_waddr",     32'(bus.rf_waddr),  32'd10);
    check("ct3_stall",     32'(bus.stall_req), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("ct_reg10",      mem[10],            32'hCAFE_0010);
    check("ct4_stall",     32'(bus.stall_req), 32'd0);

    // Starvation: four WB grants, then a forced MDU grant under stall
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(16 + i), 32'(i), 1'b1, 5'd11, 32'hBEEF_0011);
      check($sformatf("sv%0d_ready", i), 32'(bus.mdu_ready), 32'd0);
      check($sformatf("sv%0d_waddr", i), 32'(bus.rf_waddr),  32'(16 + i));
      check($sformatf("sv%0d_stall", i), 32'(bus.stall_req), 32'd0);
    end
    drive(1'b1, 5'd21, 32'h5, 1'b1, 5'd11, 32'hBEEF_0011);
    check("sv5_stall",     32'(bus.stall_req), 32'd1);
    check("sv5_ready",     32'(bus.mdu_ready), 32'd1);
    check("sv5_waddr",     32'(bus.rf_waddr),  32'd11);
    check("sv5_wdata",     bus.rf_wdata,       32'hBEEF_0011);
    drive(1'b1, 5'd21, 32'h5, 1'b0, 5'd0, 32'h0);
    check("sv6_stall",     32'(bus.stall_req), 32'd0);
    check("sv6_waddr",     32'(bus.rf_waddr),  32'd21);
    check("sv_reg11",      mem[11],            32'hBEEF_0011);

    // MDU write to $zero is acknowledged but dropped
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    check("z_ready",       32'(bus.mdu_ready), 32'd1);
    check("z_rf_we",       32'(bus.rf_we),     32'd0);

    // WB targeting $zero does not block the MDU
    drive(1'b1, 5'd0, 32'h77, 1'b1, 5'd13, 32'h0000_0D0D);
    check("wz_ready",      32'(bus.mdu_ready), 32'd1);
    check("wz_waddr",      32'(bus.rf_waddr),  32'd13);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("wz_stall",      32'(bus.stall_req), 32'd0);
    check("wz_reg0",       mem[0],             32'd0);

    // Reset while in FORCE clears stall at once and drops the pending write
    for (int i = 1; i <= 4; i++) drive(1'b1, 5'd22, 32'(i), 1'b1, 5'd12, 32'h0BAD_0012);
    drive(1'b1, 5'd22, 32'h9, 1'b1, 5'd12, 32'h0BAD_0012);
    check("rf_force_stall", 32'(bus.stall_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rf_rst_stall",  32'(bus.stall_req), 32'd0);
    check("rf_rst_rf_we",  32'(bus.rf_we),     32'd0);
    check("rf_rst_ready",  32'(bus.mdu_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rf_rst_reg12",  mem[12],            32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_stall", 32'(bus.stall_req), 32'd0);
    check("post_rst_rf_we", 32'(bus.rf_we),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
